// File: rtl/audio_sample_sequencer_pkg.sv
// Shared definitions for the audio sample sequencer: register offsets,
// control/status bit positions, FSM state encoding and register packing helpers.
package audio_seq_pkg;

    // Register offsets, decoded from addr[4:2]
    localparam logic [2:0] REG_CTRL   = 3'd0;
    localparam logic [2:0] REG_START  = 3'd1;
    localparam logic [2:0] REG_END    = 3'd2;
    localparam logic [2:0] REG_DIV    = 3'd3;
    localparam logic [2:0] REG_STATUS = 3'd4;
    localparam logic [2:0] REG_CUR    = 3'd5;
    localparam logic [2:0] REG_LAST   = 3'd6;

    // CTRL bit positions
    localparam int CTRL_ENABLE = 0;
    localparam int CTRL_LOOP   = 1;
    localparam int CTRL_IRQ_EN = 2;

    // STATUS bit positions
    localparam int STAT_RUNNING = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_OVERRUN = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_TICK = 2'd1,
        FETCH     = 2'd2,
        CAPTURE   = 2'd3
    } seq_state_t;

    // Build the 32-bit CTRL readback word
    function automatic logic [31:0] pack_ctrl(input logic en, input logic loop, input logic irq_en);
        return {29'd0, irq_en, loop, en};
    endfunction

    // Build the 32-bit STATUS readback word
    function automatic logic [31:0] pack_status(input logic running, input logic done, input logic overrun);
        return {29'd0, overrun, done, running};
    endfunction

endpackage

// File: rtl/audio_sample_sequencer_tick_gen.sv
// Sample-rate divider: counts down from DIV-1 while enabled and emits a
// registered one-cycle tick each time the count reaches zero. DIV=0 acts as 1.
module sample_tick_gen #(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] count_r;
    logic [DIV_W-1:0] reload_s;
    logic             tick_r;

    // Reload value: a programmed divider of 0 behaves exactly like 1
    always_comb begin
        reload_s = {DIV_W{1'b0}};
        if (div == {DIV_W{1'b0}}) begin
            reload_s = {DIV_W{1'b0}};
        end else begin
            reload_s = div - DIV_W'(1);
        end
    end

    // Down-counter: load restarts the period, zero reloads and fires the tick
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= {DIV_W{1'b0}};
            tick_r  <= 1'b0;
        end else if (load) begin
            count_r <= reload_s;
            tick_r  <= 1'b0;
        end else if (en) begin
            if (count_r == {DIV_W{1'b0}}) begin
                count_r <= reload_s;
                tick_r  <= 1'b1;
            end else begin
                count_r <= count_r - DIV_W'(1);
                tick_r  <= 1'b0;
            end
        end else begin
            tick_r <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/audio_sample_sequencer.sv
// Memory-mapped audio sample sequencer: bus-programmed start/end/divider,
// paced fetches from a synchronous-read sample ROM, valid/ready output to a
// consumer, one-shot or loop playback, sticky done/overrun status and irq.
module audio_sample_sequencer
    import audio_seq_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int SAMPLE_W = 16,
    parameter int DIV_W    = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic [31:0]         addr,
    input  logic [31:0]         wd,
    output logic [31:0]         rd,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [SAMPLE_W-1:0] rom_rd,
    output logic [SAMPLE_W-1:0] sample,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic                irq
);

    // Programmable registers
    logic                ctrl_en_r;
    logic                ctrl_loop_r;
    logic                ctrl_irq_en_r;
    logic [ADDR_W-1:0]   start_r;
    logic [ADDR_W-1:0]   end_r;
    logic [DIV_W-1:0]    div_r;

    // Sequencer state and status
    seq_state_t          state_r;
    logic                running_r;
    logic                done_r;
    logic                overrun_r;
    logic [ADDR_W-1:0]   cur_r;
    logic [SAMPLE_W-1:0] last_r;
    logic [ADDR_W-1:0]   rom_addr_r;
    logic [SAMPLE_W-1:0] sample_r;
    logic                sample_valid_r;
    logic [31:0]         rd_r;
    logic [31:0]         rd_next_s;
    logic                irq_r;

    // Bus decode and FSM events
    logic wr_ctrl_s;
    logic wr_start_s;
    logic wr_end_s;
    logic wr_div_s;
    logic wr_status_s;
    logic start_evt_s;
    logic abort_s;
    logic fsm_clr_en_s;
    logic sample_pending_s;
    logic tick_s;
    logic tick_en_s;
    logic unused_addr_s;

    assign wr_ctrl_s   = we && (addr[4:2] == REG_CTRL);
    assign wr_start_s  = we && (addr[4:2] == REG_START);
    assign wr_end_s    = we && (addr[4:2] == REG_END);
    assign wr_div_s    = we && (addr[4:2] == REG_DIV);
    assign wr_status_s = we && (addr[4:2] == REG_STATUS);

    // Only addr[4:2] selects a register; the rest of the byte address is ignored
    assign unused_addr_s = ^{addr[31:5], addr[1:0]};

    assign start_evt_s = wr_ctrl_s && wd[CTRL_ENABLE] && !ctrl_en_r && (state_r == IDLE);
    assign abort_s     = wr_ctrl_s && !wd[CTRL_ENABLE] && (state_r != IDLE);
    assign tick_en_s   = (state_r != IDLE);

    // A held sample is only lost when it is not being consumed on this same edge
    assign sample_pending_s = sample_valid_r && !sample_ready;

    // One-shot completion drops CTRL.enable unless an abort is taking over
    always_comb begin
        fsm_clr_en_s = 1'b0;
        if ((state_r == CAPTURE) && (cur_r == end_r) && !ctrl_loop_r && !abort_s) begin
            fsm_clr_en_s = 1'b1;
        end else begin
            fsm_clr_en_s = 1'b0;
        end
    end

    sample_tick_gen #(
        .DIV_W (DIV_W)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .load  (start_evt_s),
        .en    (tick_en_s),
        .div   (div_r),
        .tick  (tick_s)
    );

    // Writable configuration registers; FSM completion clears enable last so it wins
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_en_r     <= 1'b0;
            ctrl_loop_r   <= 1'b0;
            ctrl_irq_en_r <= 1'b0;
            start_r       <= {ADDR_W{1'b0}};
            end_r         <= {ADDR_W{1'b0}};
            div_r         <= {DIV_W{1'b0}};
        end else begin
            if (wr_ctrl_s) begin
                ctrl_en_r     <= wd[CTRL_ENABLE];
                ctrl_loop_r   <= wd[CTRL_LOOP];
                ctrl_irq_en_r <= wd[CTRL_IRQ_EN];
            end
            if (fsm_clr_en_s) begin
                ctrl_en_r <= 1'b0;
            end
            if (wr_start_s) begin
                start_r <= ADDR_W'(wd);
            end
            if (wr_end_s) begin
                end_r <= ADDR_W'(wd);
            end
            if (wr_div_s) begin
                div_r <= DIV_W'(wd);
            end
        end
    end

    // Playback FSM, status flags and consumer handshake; set events override W1C
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= IDLE;
            running_r      <= 1'b0;
            done_r         <= 1'b0;
            overrun_r      <= 1'b0;
            cur_r          <= {ADDR_W{1'b0}};
            last_r         <= {SAMPLE_W{1'b0}};
            rom_addr_r     <= {ADDR_W{1'b0}};
            sample_r       <= {SAMPLE_W{1'b0}};
            sample_valid_r <= 1'b0;
        end else begin
            if (wr_status_s && wd[STAT_DONE]) begin
                done_r <= 1'b0;
            end
            if (wr_status_s && wd[STAT_OVERRUN]) begin
                overrun_r <= 1'b0;
            end
            if (sample_valid_r && sample_ready) begin
                sample_valid_r <= 1'b0;
            end
            if (abort_s) begin
                state_r        <= IDLE;
                running_r      <= 1'b0;
                sample_valid_r <= 1'b0;
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start_evt_s) begin
                            cur_r  <= start_r;
                            done_r <= 1'b0;
                            if (start_r > end_r) begin
                                done_r <= 1'b1;
                            end else begin
                                state_r   <= WAIT_TICK;
                                running_r <= 1'b1;
                            end
                        end
                    end
                    WAIT_TICK: begin
                        if (tick_s) begin
                            if (sample_pending_s) begin
                                overrun_r <= 1'b1;
                            end else begin
                                rom_addr_r <= cur_r;
                                state_r    <= FETCH;
                            end
                        end
                    end
                    FETCH: begin
                        state_r <= CAPTURE;
                    end
                    CAPTURE: begin
                        sample_r       <= rom_rd;
                        last_r         <= rom_rd;
                        sample_valid_r <= 1'b1;
                        if (cur_r == end_r) begin
                            if (ctrl_loop_r) begin
                                cur_r   <= start_r;
                                state_r <= WAIT_TICK;
                            end else begin
                                done_r    <= 1'b1;
                                running_r <= 1'b0;
                                state_r   <= IDLE;
                            end
                        end else begin
                            cur_r   <= cur_r + ADDR_W'(1);
                            state_r <= WAIT_TICK;
                        end
                    end
                    default: begin
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

    // Bus read mux selecting the addressed register
    always_comb begin
        rd_next_s = 32'd0;
        case (addr[4:2])
            REG_CTRL:   rd_next_s = pack_ctrl(ctrl_en_r, ctrl_loop_r, ctrl_irq_en_r);
            REG_START:  rd_next_s = 32'(start_r);
            REG_END:    rd_next_s = 32'(end_r);
            REG_DIV:    rd_next_s = 32'(div_r);
            REG_STATUS: rd_next_s = pack_status(running_r, done_r, overrun_r);
            REG_CUR:    rd_next_s = 32'(cur_r);
            REG_LAST:   rd_next_s = 32'(last_r);
            default:    rd_next_s = 32'd0;
        endcase
    end

    // Registered read data and interrupt level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_r  <= 32'd0;
            irq_r <= 1'b0;
        end else begin
            rd_r  <= rd_next_s;
            irq_r <= ctrl_irq_en_r && (done_r || overrun_r);
        end
    end

    assign rd           = rd_r;
    assign rom_addr     = rom_addr_r;
    assign sample       = sample_r;
    assign sample_valid = sample_valid_r;
    assign irq          = irq_r;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Directed self-checking bench for audio_sample_sequencer with a synchronous ROM model.
module tb_audio_sample_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [31:0] rom_addr;
    logic [15:0] rom_rd = 16'd0;
    logic [15:0] sample;
    logic        sample_valid;
    logic        sample_ready;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    // Fetch and delivered-sample logs filled by the monitor
    logic [31:0] fetch_addr [0:63];
    int          fetch_cyc  [0:63];
    int          n_fetch = 0;
    logic [15:0] smp_log    [0:63];
    int          n_smp = 0;
    logic [31:0] prev_addr = 32'd0;
    int          cyc = 0;

    localparam logic [31:0] A_CTRL   = 32'h00;
    localparam logic [31:0] A_START  = 32'h04;
    localparam logic [31:0] A_END    = 32'h08;
    localparam logic [31:0] A_DIV    = 32'h0C;
    localparam logic [31:0] A_STATUS = 32'h10;
    localparam logic [31:0] A_CUR    = 32'h14;
    localparam logic [31:0] A_LAST   = 32'h18;

    audio_sample_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .we           (we),
        .addr         (addr),
        .wd           (wd),
        .rd           (rd),
        .rom_addr     (rom_addr),
        .rom_rd       (rom_rd),
        .sample       (sample),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] rom_val(input logic [31:0] a);
        return 16'h1000 + (a[15:0] * 16'd3);
    endfunction

    // Synchronous-read sample ROM
    always @(posedge clk) rom_rd <= rom_val(rom_addr);

    // Cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // Log every new ROM address and every accepted sample, sampled mid-cycle
    always @(negedge clk) begin
        if (rom_addr !== prev_addr && n_fetch < 64) begin
            fetch_addr[n_fetch] <= rom_addr;
            fetch_cyc[n_fetch]  <= cyc;
            n_fetch             <= n_fetch + 1;
        end
        prev_addr <= rom_addr;
        if (sample_valid === 1'b1 && sample_ready === 1'b1 && n_smp < 64) begin
            smp_log[n_smp] <= sample;
            n_smp          <= n_smp + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        addr = a;
        wd   = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        addr = a;
        we   = 1'b0;
        @(posedge clk);
        #1;
        d = rd;
    endtask

    initial begin
        logic [31:0] r;
        int base_f;
        int base_s;
        int w;
        logic seen;

        reset = 1'b1;
        we = 1'b0;
        addr = 32'd0;
        wd = 32'd0;
        sample_ready = 1'b0;

        // Reset state
        step(3);
        check("rst_rom_addr", rom_addr, 32'd0);
        check("rst_sample", {16'd0, sample}, 32'd0);
        check("rst_valid", {31'd0, sample_valid}, 32'd0);
        check("rst_rd", rd, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        step(1);

        // 1) one-shot 10..13, DIV=4, consumer always ready
        sample_ready = 1'b1;
        bus_write(A_START, 32'd10);
        bus_write(A_END, 32'd13);
        bus_write(A_DIV, 32'd4);
        base_f = n_fetch;
        base_s = n_smp;
        bus_write(A_CTRL, 32'd1);
        step(40);
        check("t1_fetch_cnt", n_fetch - base_f, 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("t1_addr", fetch_addr[base_f + i], 32'd10 + i);
            check("t1_sample", {16'd0, smp_log[base_s + i]}, {16'd0, rom_val(32'd10 + i)});
        end
        for (int i = 1; i < 4; i++) begin
            check("t1_spacing", fetch_cyc[base_f + i] - fetch_cyc[base_f + i - 1], 32'd4);
        end
        check("t1_smp_cnt", n_smp - base_s, 32'd4);
        bus_read(A_STATUS, r);
        check("t1_status", r, 32'd2);
        check("t1_irq", {31'd0, irq}, 32'd0);
        bus_read(A_CTRL, r);
        check("t1_ctrl_cleared", r, 32'd0);
        bus_read(A_LAST, r);
        check("t1_last", r, {16'd0, rom_val(32'd13)});

        // 2) loop mode, 10 ticks
        base_f = n_fetch;
        bus_write(A_CTRL, 32'd3);
        w = 0;
        while ((n_fetch - base_f) < 10 && w < 300) begin
            step(1);
            w++;
        end
        check("t2_fetch_cnt", n_fetch - base_f, 32'd10);
        for (int i = 0; i < 10; i++) begin
            check("t2_addr", fetch_addr[base_f + i], 32'd10 + (i % 4));
        end
        bus_read(A_STATUS, r);
        check("t2_status", r, 32'd1);
        bus_write(A_CTRL, 32'd0);

        // 3) consumer stalls, DIV=5, irq enabled
        sample_ready = 1'b0;
        bus_write(A_STATUS, 32'd6);
        bus_write(A_DIV, 32'd5);
        base_f = n_fetch;
        bus_write(A_CTRL, 32'd5);
        seen = 1'b0;
        w = 0;
        while (!seen && w < 100) begin
            step(1);
            seen = (irq === 1'b1);
            w++;
        end
        check("t3_irq_set", {31'd0, seen}, 32'd1);
        check("t3_sample_held", {16'd0, sample}, {16'd0, rom_val(32'd10)});
        check("t3_valid_held", {31'd0, sample_valid}, 32'd1);
        bus_read(A_STATUS, r);
        check("t3_status_ovr", r, 32'd5);
        bus_write(A_STATUS, 32'd4);
        bus_read(A_STATUS, r);
        check("t3_status_clr", r, 32'd1);
        check("t3_irq_clr", {31'd0, irq}, 32'd0);
        bus_read(A_CUR, r);
        check("t3_cur", r, 32'd11);
        check("t3_fetch_cnt", n_fetch - base_f, 32'd1);
        bus_write(A_CTRL, 32'd0);
        check("t3_abort_valid", {31'd0, sample_valid}, 32'd0);
        sample_ready = 1'b1;

        // 4) abort during FETCH
        bus_write(A_STATUS, 32'd6);
        bus_write(A_DIV, 32'd4);
        bus_write(A_START, 32'd30);
        bus_write(A_END, 32'd40);
        base_f = n_fetch;
        bus_write(A_CTRL, 32'd1);
        w = 0;
        while (rom_addr !== 32'd31 && w < 100) begin
            step(1);
            w++;
        end
        check("t4_reach_fetch", rom_addr, 32'd31);
        bus_write(A_CTRL, 32'd0);
        check("t4_valid", {31'd0, sample_valid}, 32'd0);
        bus_read(A_STATUS, r);
        check("t4_status", r, 32'd0);
        bus_read(A_CUR, r);
        check("t4_cur", r, 32'd31);
        step(20);
        check("t4_no_more_fetch", n_fetch - base_f, 32'd2);

        // 5) START > END
        bus_write(A_STATUS, 32'd6);
        bus_write(A_START, 32'd20);
        bus_write(A_END, 32'd19);
        base_f = n_fetch;
        bus_write(A_CTRL, 32'd1);
        bus_read(A_STATUS, r);
        check("t5_status", r, 32'd2);
        step(10);
        check("t5_no_fetch", n_fetch - base_f, 32'd0);
        bus_write(A_CTRL, 32'd0);

        // 6) DIV=0, single fetch at the top index
        bus_write(A_STATUS, 32'd6);
        bus_write(A_DIV, 32'd0);
        bus_write(A_START, 32'hFFFF_FFFF);
        bus_write(A_END, 32'hFFFF_FFFF);
        base_f = n_fetch;
        base_s = n_smp;
        bus_write(A_CTRL, 32'd1);
        step(15);
        check("t6_fetch_cnt", n_fetch - base_f, 32'd1);
        check("t6_addr", fetch_addr[base_f], 32'hFFFF_FFFF);
        check("t6_sample", {16'd0, smp_log[base_s]}, {16'd0, rom_val(32'hFFFF_FFFF)});
        bus_read(A_STATUS, r);
        check("t6_status", r, 32'd2);
        bus_read(A_CUR, r);
        check("t6_cur", r, 32'hFFFF_FFFF);

        // 7) asynchronous reset mid-run
        bus_write(A_DIV, 32'd4);
        bus_write(A_START, 32'd50);
        bus_write(A_END, 32'd100);
        bus_write(A_CTRL, 32'd3);
        bus_read(A_CTRL, r);
        check("t7_ctrl_rb", r, 32'd3);
        step(12);
        #2;
        reset = 1'b1;
        #1;
        check("t7_rst_rom_addr", rom_addr, 32'd0);
        check("t7_rst_rd", rd, 32'd0);
        check("t7_rst_sample", {16'd0, sample}, 32'd0);
        step(2);
        reset = 1'b0;
        bus_read(A_CTRL, r);
        check("t7_ctrl_after", r, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
